ps2_keyboard_tx: RTL and testbench

Device-side PS/2 transmitter: emulates a keyboard by serialising queued scan-code bytes onto `ps2_clk`/`ps2_data` as standard 11-bit frames. It is the opposite end of the existing PS/2 receive path. It drives the keyboard input of the FSM/keyboard test top in self-checking benches and on-board loopback. Bytes are written into a small FIFO and sent back-to-back, with an enforced inter-frame gap.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_tx_fifo.sv | 60 ++++++
 rtl/ps2_keyboard_tx.sv | 145 ++++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, state encoding and parity helper
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } ps2_state_e;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// rtl/ps2_tx_fifo.sv - small synchronous byte queue feeding the PS/2 transmitter
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Requests are qualified here so a push on full or pop on empty never moves a pointer
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// rtl/ps2_keyboard_tx.sv - device-side PS/2 transmitter emulating a keyboard
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_HALF   = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int CW = $clog2(CLK_DIV);
    // One cycle of the gap is spent in IDLE doing the pop, so the frame-start
    // spacing under a backlog comes out at exactly (22+GAP_HALF)*CLK_DIV.
    localparam int GAP_LEN = GAP_HALF * CLK_DIV - 1;
    localparam int GW = $clog2(GAP_LEN + 1);

    ps2_state_e       state;
    logic [CW-1:0]    half_cnt;
    logic             phase_low;
    logic [3:0]       bit_idx;
    logic [9:0]       shreg;
    logic [GW-1:0]    gap_cnt;

    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [10:0]      next_frame;

    // Pop only from IDLE; the FIFO has no bypass so a fresh byte waits one cycle
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign next_frame = {1'b1, ps2_odd_parity(fifo_dout), fifo_dout, 1'b0};
    assign full       = fifo_full;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame sequencer: bit timing, shifter and line drivers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            half_cnt  <= '0;
            phase_low <= 1'b0;
            bit_idx   <= '0;
            shreg     <= '1;
            gap_cnt   <= '0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (fifo_pop) begin
                        ps2_data  <= next_frame[0];
                        shreg     <= next_frame[10:1];
                        half_cnt  <= '0;
                        phase_low <= 1'b0;
                        bit_idx   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (half_cnt == CW'(CLK_DIV - 1)) begin
                        half_cnt <= '0;
                        if (!phase_low) begin
                            phase_low <= 1'b1;
                            ps2_clk   <= 1'b0;
                        end else begin
                            // data only moves at the start of a high phase
                            phase_low <= 1'b0;
                            ps2_clk   <= 1'b1;
                            if (bit_idx == 4'(PS2_FRAME_BITS - 1)) begin
                                ps2_data <= 1'b1;
                                gap_cnt  <= '0;
                                state    <= GAP;
                            end else begin
                                ps2_data <= shreg[0];
                                shreg    <= {1'b1, shreg[9:1]};
                                bit_idx  <= bit_idx + 1'b1;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                GAP: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (gap_cnt == GW'(GAP_LEN - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                end
            endcase
        end
    end

    // Sticky drop flag: any write presented while the queue is full
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Activity flag covering frame, gap and any queued bytes
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy <= 1'b0;
        end else begin
            busy <= (state != IDLE) || (fifo_count != '0);
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb/tb_ps2_keyboard_tx.sv - directed self-checking bench for ps2_keyboard_tx
module tb_ps2_keyboard_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_HALF   = 4;
    localparam int SPACING    = 104;  // (22+4)*4
    localparam int BUSY_FALL  = 104;  // from first start-bit cycle to busy low

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ps2_keyboard_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_HALF   (GAP_HALF)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples data on falling ps2_clk, collects 11-bit frames
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    int          nbits = 0;
    logic [10:0] cur = '0;
    int          cur_start = 0;
    int          cur_fe0 = 0;
    logic [10:0] fr_q[$];
    int          st_q[$];
    int          fe_q[$];

    always @(negedge clk) begin
        if (!clrn) begin
            nbits     <= 0;
            prev_clk  <= 1'b1;
            prev_data <= 1'b1;
        end else begin
            prev_clk  <= ps2_clk;
            prev_data <= ps2_data;
            if (nbits == 0 && prev_data && !ps2_data && ps2_clk)
                cur_start <= cyc;
            if (prev_clk && !ps2_clk) begin
                if (nbits == 0)
                    cur_fe0 <= cyc;
                if (nbits == 10) begin
                    fr_q.push_back({ps2_data, cur[9:0]});
                    st_q.push_back(cur_start);
                    fe_q.push_back(cur_fe0);
                    nbits <= 0;
                end else begin
                    cur[nbits] <= ps2_data;
                    nbits      <= nbits + 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 clrn = 1'b0;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        fr_q.delete();
        st_q.delete();
        fe_q.delete();
    endtask

    task automatic wr(input logic [7:0] d);
        @(posedge clk);
        #1 wr_en = 1'b1;
        wr_data = d;
    endtask

    task automatic wr_stop();
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic get_frame(output logic [10:0] bits, output int st, output int fe, output bit ok);
        int waited = 0;
        while (fr_q.size() == 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (fr_q.size() > 0) begin
            bits = fr_q.pop_front();
            st   = st_q.pop_front();
            fe   = fe_q.pop_front();
            ok   = 1'b1;
        end else begin
            bits = 'x;
            st   = 0;
            fe   = 0;
            ok   = 1'b0;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ps2_clk !== 1'b1) begin n_fail++; $display("FAIL reset_ps2_clk: got %b expected 1", ps2_clk); end
        n_checks++;
        if (ps2_data !== 1'b1) begin n_fail++; $display("FAIL reset_ps2_data: got %b expected 1", ps2_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(posedge clk);
        #1 clrn = 1'b1;
    endtask

    task automatic test_idle();
        int bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_lines: got %0d non-idle samples expected 0", bad); end
    endtask

    task automatic test_frame_1c();
        logic [10:0] bits, exp;
        int st, fe, wcyc, fall_cyc;
        bit ok;
        exp = {1'b1, 1'b0, 8'h1C, 1'b0};
        wr(8'h1C);
        wcyc = cyc;
        wr_stop();
        get_frame(bits, st, fe, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL frame_1c_timeout: got no frame expected one"); end
        n_checks++;
        if (bits !== exp) begin n_fail++; $display("FAIL frame_1c_bits: got %b expected %b", bits, exp); end
        n_checks++;
        if (st - wcyc !== 2) begin n_fail++; $display("FAIL frame_1c_latency: got %0d expected 2", st - wcyc); end
        n_checks++;
        if (fe - st !== CLK_DIV) begin n_fail++; $display("FAIL frame_1c_first_fall: got %0d expected %0d", fe - st, CLK_DIV); end
        fall_cyc = -1;
        for (int i = 0; i < 200 && fall_cyc < 0; i++) begin
            @(negedge clk);
            if (busy === 1'b0) fall_cyc = cyc;
        end
        n_checks++;
        if (fall_cyc - st !== BUSY_FALL) begin n_fail++; $display("FAIL frame_1c_busy_fall: got %0d expected %0d", fall_cyc - st, BUSY_FALL); end
        n_checks++;
        if ({ps2_clk, ps2_data} !== 2'b11) begin n_fail++; $display("FAIL frame_1c_idle_after: got %b expected 11", {ps2_clk, ps2_data}); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] b0, b1, e0, e1;
        int s0, s1, f0, f1;
        bit ok0, ok1;
        e0 = {1'b1, 1'b1, 8'h00, 1'b0};
        e1 = {1'b1, 1'b1, 8'hFF, 1'b0};
        wr(8'h00);
        wr(8'hFF);
        wr_stop();
        get_frame(b0, s0, f0, ok0);
        get_frame(b1, s1, f1, ok1);
        n_checks++;
        if (!(ok0 && ok1)) begin n_fail++; $display("FAIL b2b_timeout: got %b%b expected 11", ok0, ok1); end
        n_checks++;
        if (b0 !== e0) begin n_fail++; $display("FAIL b2b_frame00: got %b expected %b", b0, e0); end
        n_checks++;
        if (b1 !== e1) begin n_fail++; $display("FAIL b2b_frameff: got %b expected %b", b1, e1); end
        n_checks++;
        if (s1 - s0 !== SPACING) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", s1 - s0, SPACING); end
    endtask

    task automatic test_overflow();
        logic [10:0] b, e;
        logic [7:0]  d;
        int s, f, prev_s;
        bit ok;
        do_reset();
        for (int i = 0; i < 6; i++) wr(8'h11 + 8'(i));
        wr_stop();
        @(negedge clk);
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        prev_s = 0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            e = {1'b1, ~^d, d, 1'b0};
            get_frame(b, s, f, ok);
            n_checks++;
            if (!ok || b !== e) begin n_fail++; $display("FAIL ovf_frame%0d: got %b expected %b", i, b, e); end
            if (i > 0) begin
                n_checks++;
                if (s - prev_s !== SPACING) begin n_fail++; $display("FAIL ovf_spacing%0d: got %0d expected %0d", i, s - prev_s, SPACING); end
            end
            prev_s = s;
        end
        repeat (150) @(negedge clk);
        n_checks++;
        if (fr_q.size() !== 0) begin n_fail++; $display("FAIL ovf_extra_frame: got %0d frames expected 0", fr_q.size()); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        n_checks++;
        if (full !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got full=%b busy=%b expected 0 0", full, busy); end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] b, e;
        int s, f;
        bit ok;
        e = {1'b1, 1'b0, 8'h1C, 1'b0};
        wr(8'hAA);
        wr(8'h55);
        wr_stop();
        repeat (42) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (nbits !== 5 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_bit5: got nbits=%0d busy=%b expected 5 1", nbits, busy); end
        #1 clrn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ps2_clk, ps2_data, busy} !== 3'b110) begin n_fail++; $display("FAIL mid_reset_lines: got %b expected 110", {ps2_clk, ps2_data, busy}); end
        @(posedge clk);
        #1 clrn = 1'b1;
        fr_q.delete();
        st_q.delete();
        fe_q.delete();
        wr(8'h1C);
        wr_stop();
        get_frame(b, s, f, ok);
        n_checks++;
        if (!ok || b !== e) begin n_fail++; $display("FAIL mid_clean_frame: got %b expected %b", b, e); end
        repeat (150) @(negedge clk);
        n_checks++;
        if (fr_q.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_queue_discarded: got %0d frames busy=%b expected 0 0", fr_q.size(), busy); end
    endtask

    task automatic test_loopback();
        logic [10:0] b, e;
        logic [7:0]  exp_bytes [3];
        int s, f;
        bit ok;
        exp_bytes[0] = 8'hF0;
        exp_bytes[1] = 8'h1C;
        exp_bytes[2] = 8'h1C;
        wr(8'hF0);
        wr(8'h1C);
        wr(8'h1C);
        wr_stop();
        for (int i = 0; i < 3; i++) begin
            get_frame(b, s, f, ok);
            e = {1'b1, ~^exp_bytes[i], exp_bytes[i], 1'b0};
            n_checks++;
            if (!ok || b !== e) begin n_fail++; $display("FAIL loop_frame%0d: got %b expected %b", i, b, e); end
            n_checks++;
            if (b[8:1] !== exp_bytes[i]) begin n_fail++; $display("FAIL loop_byte%0d: got %h expected %h", i, b[8:1], exp_bytes[i]); end
        end
        repeat (150) @(negedge clk);
        n_checks++;
        if (fr_q.size() !== 0) begin n_fail++; $display("FAIL loop_rx_overflow: got %0d extra frames expected 0", fr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame_1c();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
